// File: rtl/acq_sched_pkg.sv
// Shared definitions for the acquisition round scheduler: one-hot state
// encoding and the sample size in bytes used for DDR address stepping.
package acq_sched_pkg;

  localparam int BYTES_PER_SAMPLE = 2;

  typedef enum logic [6:0] {
    ST_IDLE      = 7'b000_0001,
    ST_ARM       = 7'b000_0010,
    ST_WAIT_TRIG = 7'b000_0100,
    ST_CAPTURE   = 7'b000_1000,
    ST_REQ       = 7'b001_0000,
    ST_WAIT_DONE = 7'b010_0000,
    ST_FINISH    = 7'b100_0000
  } state_t;

endpackage

// File: rtl/acq_round_sched_if.sv
// Burst request channel between the round scheduler (master) and the DDR
// writer (slave).
interface acq_round_sched_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);

  logic              Wr_Req;
  logic [ADDR_W-1:0] Wr_Addr;
  logic [CNT_W-1:0]  Wr_Len;
  logic              Wr_Ack;
  logic              Wr_Done;

  modport master (output Wr_Req, Wr_Addr, Wr_Len, input Wr_Ack, Wr_Done);
  modport slave  (input Wr_Req, Wr_Addr, Wr_Len, output Wr_Ack, Wr_Done);

endinterface

// File: rtl/acq_timeout_cnt.sv
// Trigger-wait watchdog: counts enabled cycles and flags the cycle in which
// the limit is reached; a zero limit never expires.
module acq_timeout_cnt (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        clear,
  input  logic        enable,
  input  logic [31:0] limit,
  output logic        expired
);

  logic [31:0] count;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)      count <= 32'd0;
    else if (clear)  count <= 32'd0;
    else if (enable) count <= count + 32'd1;
  end

  // Flagged one cycle early so the state change lands exactly limit cycles after entry
  assign expired = enable && (limit != 32'd0) && (count == limit - 32'd1);

endmodule

// File: rtl/acq_round_sched.sv
// Multi-round acquisition scheduler: arms the trigger detector, counts samples,
// requests one DDR burst per round. Define ACQ_TIMEOUT_EN for the trigger-wait timeout.
module acq_round_sched
  import acq_sched_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Cfg_Enable,
  input  logic [CNT_W-1:0]  Cfg_Round_Num,
  input  logic [CNT_W-1:0]  Cfg_Samples,
  input  logic [ADDR_W-1:0] Cfg_Base_Addr,
  input  logic [31:0]       Cfg_Timeout,
  input  logic              ADC_Conv_Done,
  input  logic              DDR_WR_Start,
  output logic              Start_Round_Acq,
  acq_round_sched_if.master wr,
  output logic [CNT_W-1:0]  Round_Cnt,
  output logic              Busy,
  output logic              Job_Done,
  output logic              Timeout_Err
);

  state_t            state;
  logic              en_q;
  logic              en_rise;
  logic              abort_q;
  logic [CNT_W-1:0]  rounds_q;
  logic [CNT_W-1:0]  samples_q;
  logic [CNT_W-1:0]  smp_cnt;
  logic [CNT_W-1:0]  round_nxt;
  logic [CNT_W-1:0]  rounds_eff;
  logic [CNT_W-1:0]  samples_eff;
  logic [ADDR_W-1:0] addr_step;
  logic              timeout_hit;

  assign en_rise     = Cfg_Enable & ~en_q;
  assign rounds_eff  = (Cfg_Round_Num == '0) ? CNT_W'(1) : Cfg_Round_Num;
  assign samples_eff = (Cfg_Samples == '0) ? CNT_W'(1) : Cfg_Samples;
  assign round_nxt   = Round_Cnt + CNT_W'(1);
  assign addr_step   = ADDR_W'(samples_q) * ADDR_W'(BYTES_PER_SAMPLE);
  assign Busy        = (state != ST_IDLE);

`ifdef ACQ_TIMEOUT_EN
  logic [31:0] timeout_q;
  logic        err_q;

  acq_timeout_cnt u_timeout (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .clear   (state != ST_WAIT_TRIG),
    .enable  (state == ST_WAIT_TRIG),
    .limit   (timeout_q),
    .expired (timeout_hit)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      timeout_q <= 32'd0;
      err_q     <= 1'b0;
    end else if (state == ST_IDLE && en_rise) begin
      timeout_q <= Cfg_Timeout;
      err_q     <= 1'b0;
    end else if (state == ST_WAIT_TRIG && Cfg_Enable && !DDR_WR_Start && timeout_hit) begin
      err_q     <= 1'b1;
    end
  end

  assign Timeout_Err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^Cfg_Timeout;
  assign timeout_hit    = 1'b0;
  assign Timeout_Err    = 1'b0;
`endif

  // Pulse outputs default low every cycle and are raised on entry to ARM / FINISH.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state           <= ST_IDLE;
      en_q            <= 1'b0;
      abort_q         <= 1'b0;
      rounds_q        <= '0;
      samples_q       <= '0;
      smp_cnt         <= '0;
      Round_Cnt       <= '0;
      Start_Round_Acq <= 1'b0;
      Job_Done        <= 1'b0;
      wr.Wr_Req       <= 1'b0;
      wr.Wr_Addr      <= '0;
      wr.Wr_Len       <= '0;
    end else begin
      en_q            <= Cfg_Enable;
      Start_Round_Acq <= 1'b0;
      Job_Done        <= 1'b0;
      case (state)
        ST_IDLE: begin
          abort_q <= 1'b0;
          if (en_rise) begin
            rounds_q        <= rounds_eff;
            samples_q       <= samples_eff;
            wr.Wr_Len       <= samples_eff;
            wr.Wr_Addr      <= Cfg_Base_Addr;
            Round_Cnt       <= '0;
            Start_Round_Acq <= 1'b1;
            state           <= ST_ARM;
          end
        end
        ST_ARM: state <= Cfg_Enable ? ST_WAIT_TRIG : ST_IDLE;
        ST_WAIT_TRIG: begin
          if (!Cfg_Enable) begin
            state <= ST_IDLE;
          end else if (DDR_WR_Start) begin
            smp_cnt <= ADC_Conv_Done ? CNT_W'(1) : CNT_W'(0);
            state   <= ST_CAPTURE;
          end else if (timeout_hit) begin
            Job_Done <= 1'b1;
            state    <= ST_FINISH;
          end
        end
        ST_CAPTURE: begin
          if (!Cfg_Enable) begin
            state <= ST_IDLE;
          end else if (smp_cnt == samples_q) begin
            wr.Wr_Req <= 1'b1;
            state     <= ST_REQ;
          end else if (ADC_Conv_Done) begin
            smp_cnt <= smp_cnt + CNT_W'(1);
            if (smp_cnt + CNT_W'(1) == samples_q) begin
              wr.Wr_Req <= 1'b1;
              state     <= ST_REQ;
            end
          end
        end
        // An abort here is only remembered; the burst must finish before IDLE.
        ST_REQ, ST_WAIT_DONE: begin
          if (!Cfg_Enable) abort_q <= 1'b1;
          if (state == ST_REQ && wr.Wr_Ack) begin
            wr.Wr_Req <= 1'b0;
            state     <= ST_WAIT_DONE;
          end
          if (wr.Wr_Done && (state == ST_WAIT_DONE || wr.Wr_Ack)) begin
            Round_Cnt  <= round_nxt;
            wr.Wr_Addr <= wr.Wr_Addr + addr_step;
            if (abort_q || !Cfg_Enable) begin
              state <= ST_IDLE;
            end else if (round_nxt == rounds_q) begin
              Job_Done <= 1'b1;
              state    <= ST_FINISH;
            end else begin
              Start_Round_Acq <= 1'b1;
              state           <= ST_ARM;
            end
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acq_round_sched.sv
// Directed self-checking bench for acq_round_sched; the timeout scenario
// follows ACQ_TIMEOUT_EN.
module tb_acq_round_sched;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Cfg_Enable = 1'b0;
  logic [15:0] Cfg_Round_Num = '0;
  logic [15:0] Cfg_Samples = '0;
  logic [31:0] Cfg_Base_Addr = '0;
  logic [31:0] Cfg_Timeout = '0;
  logic        ADC_Conv_Done = 1'b0;
  logic        DDR_WR_Start = 1'b0;
  logic        Start_Round_Acq;
  logic [15:0] Round_Cnt;
  logic        Busy, Job_Done, Timeout_Err;

  int checks = 0;
  int errors = 0;
  int job_done_cnt = 0;
  int wr_req_cycles = 0;

  acq_round_sched_if #(.ADDR_W(32), .CNT_W(16)) wr ();

  acq_round_sched #(.ADDR_W(32), .CNT_W(16)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Cfg_Enable(Cfg_Enable),
    .Cfg_Round_Num(Cfg_Round_Num), .Cfg_Samples(Cfg_Samples),
    .Cfg_Base_Addr(Cfg_Base_Addr), .Cfg_Timeout(Cfg_Timeout),
    .ADC_Conv_Done(ADC_Conv_Done), .DDR_WR_Start(DDR_WR_Start),
    .Start_Round_Acq(Start_Round_Acq), .wr(wr.master), .Round_Cnt(Round_Cnt),
    .Busy(Busy), .Job_Done(Job_Done), .Timeout_Err(Timeout_Err)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (Job_Done === 1'b1) job_done_cnt++;
    if (wr.Wr_Req === 1'b1) wr_req_cycles++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic start_job(input logic [15:0] rounds, input logic [15:0] samples,
                           input logic [31:0] base, input logic [31:0] timeout);
    @(negedge Clk);
    Cfg_Round_Num = rounds; Cfg_Samples = samples;
    Cfg_Base_Addr = base;   Cfg_Timeout = timeout;
    Cfg_Enable = 1'b1;
    @(negedge Clk);
  endtask

  task automatic end_job();
    Cfg_Enable = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic wait_arm(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (Start_Round_Acq === 1'b1) begin ok = 1'b1; break; end
      @(negedge Clk);
    end
  endtask

  // Trigger together with sample 1, then n-1 further strobes on consecutive cycles.
  task automatic do_capture(input int n);
    @(negedge Clk); DDR_WR_Start = 1'b1; ADC_Conv_Done = 1'b1;
    for (int i = 1; i < n; i++) begin
      @(negedge Clk); DDR_WR_Start = 1'b0; ADC_Conv_Done = 1'b1;
    end
    @(negedge Clk); DDR_WR_Start = 1'b0; ADC_Conv_Done = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (wr.Wr_Req === 1'b1) begin ok = 1'b1; break; end
      @(negedge Clk);
    end
  endtask

  task automatic serve_burst(input int ack_delay, output logic [31:0] addr,
                             output logic [15:0] len, output bit stable);
    addr = wr.Wr_Addr; len = wr.Wr_Len; stable = 1'b1;
    for (int k = 0; k < ack_delay; k++) begin
      @(negedge Clk);
      if (wr.Wr_Req !== 1'b1 || wr.Wr_Addr !== addr || wr.Wr_Len !== len) stable = 1'b0;
    end
    wr.Wr_Ack = 1'b1;
    @(negedge Clk); wr.Wr_Ack = 1'b0;
    @(negedge Clk); wr.Wr_Done = 1'b1;
    @(negedge Clk); wr.Wr_Done = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge Clk);
    checks += 8;
    if (Busy !== 1'b0)            begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", Busy); end
    if (wr.Wr_Req !== 1'b0)       begin errors++; $display("[TB] FAIL reset_wr_req: got %b want 0", wr.Wr_Req); end
    if (Start_Round_Acq !== 1'b0) begin errors++; $display("[TB] FAIL reset_start: got %b want 0", Start_Round_Acq); end
    if (Job_Done !== 1'b0)        begin errors++; $display("[TB] FAIL reset_job_done: got %b want 0", Job_Done); end
    if (Timeout_Err !== 1'b0)     begin errors++; $display("[TB] FAIL reset_timeout_err: got %b want 0", Timeout_Err); end
    if (Round_Cnt !== 16'd0)      begin errors++; $display("[TB] FAIL reset_round_cnt: got %h want 0", Round_Cnt); end
    if (wr.Wr_Addr !== 32'd0)     begin errors++; $display("[TB] FAIL reset_wr_addr: got %h want 0", wr.Wr_Addr); end
    if (wr.Wr_Len !== 16'd0)      begin errors++; $display("[TB] FAIL reset_wr_len: got %h want 0", wr.Wr_Len); end
    Rst_n = 1'b1;
    @(negedge Clk);
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_after_reset: busy got %b want 0", Busy); end
  endtask

  task automatic test_basic();
    bit ok, st; logic [31:0] a; logic [15:0] l;
    int jd0 = job_done_cnt;
    start_job(16'd2, 16'd4, 32'h1000, 32'd0);
    for (int r = 0; r < 2; r++) begin
      wait_arm(ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL basic_arm%0d: got no arm pulse want pulse", r); end
      do_capture(4);
      wait_req(ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL basic_req%0d: got no Wr_Req want Wr_Req", r); end
      serve_burst(1, a, l, st);
      checks += 3;
      if (a !== 32'h1000 + 32'(8 * r)) begin errors++; $display("[TB] FAIL basic_addr%0d: got %h want %h", r, a, 32'h1000 + 32'(8 * r)); end
      if (l !== 16'd4) begin errors++; $display("[TB] FAIL basic_len%0d: got %0d want 4", r, l); end
      if (Round_Cnt !== 16'(r + 1)) begin errors++; $display("[TB] FAIL basic_round_cnt%0d: got %0d want %0d", r, Round_Cnt, r + 1); end
    end
    checks += 2;
    if (Job_Done !== 1'b1) begin errors++; $display("[TB] FAIL basic_job_done: got %b want 1", Job_Done); end
    if (Busy !== 1'b1)     begin errors++; $display("[TB] FAIL basic_busy_finish: got %b want 1", Busy); end
    repeat (6) @(negedge Clk);
    checks += 3;
    if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_no_restart: busy got %b want 0", Busy); end
    if (job_done_cnt - jd0 != 1) begin errors++; $display("[TB] FAIL basic_job_done_count: got %0d want 1", job_done_cnt - jd0); end
    if (Round_Cnt !== 16'd2) begin errors++; $display("[TB] FAIL basic_final_rounds: got %0d want 2", Round_Cnt); end
    end_job();
  endtask

  task automatic test_ack_delay();
    bit ok, st; logic [31:0] a; logic [15:0] l;
    start_job(16'd1, 16'd3, 32'h2000, 32'd0);
    wait_arm(ok); do_capture(3); wait_req(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL ackdly_req: got no Wr_Req want Wr_Req"); end
    serve_burst(5, a, l, st);
    checks += 4;
    if (st !== 1'b1)       begin errors++; $display("[TB] FAIL ackdly_stable: got %b want 1", st); end
    if (a !== 32'h2000)    begin errors++; $display("[TB] FAIL ackdly_addr: got %h want 2000", a); end
    if (l !== 16'd3)       begin errors++; $display("[TB] FAIL ackdly_len: got %0d want 3", l); end
    if (Job_Done !== 1'b1) begin errors++; $display("[TB] FAIL ackdly_job_done: got %b want 1", Job_Done); end
    end_job();
  endtask

  task automatic test_wrap();
    bit ok, st; logic [31:0] a; logic [15:0] l;
    logic [31:0] exp_addr [2] = '{32'hFFFF_FFFC, 32'h0000_0004};
    start_job(16'd2, 16'd4, 32'hFFFF_FFFC, 32'd0);
    for (int r = 0; r < 2; r++) begin
      wait_arm(ok); do_capture(4); wait_req(ok);
      serve_burst(1, a, l, st);
      checks++;
      if (a !== exp_addr[r]) begin errors++; $display("[TB] FAIL wrap_addr%0d: got %h want %h", r, a, exp_addr[r]); end
    end
    end_job();
  endtask

  task automatic test_zero_cfg_same_cycle();
    bit ok;
    start_job(16'd0, 16'd0, 32'h0500, 32'd0);
    wait_arm(ok); do_capture(1); wait_req(ok);
    checks += 2;
    if (!ok) begin errors++; $display("[TB] FAIL zero_req: got no Wr_Req want Wr_Req"); end
    if (wr.Wr_Len !== 16'd1) begin errors++; $display("[TB] FAIL zero_len: got %0d want 1", wr.Wr_Len); end
    wr.Wr_Ack = 1'b1; wr.Wr_Done = 1'b1;
    @(negedge Clk); wr.Wr_Ack = 1'b0; wr.Wr_Done = 1'b0;
    checks += 4;
    if (Job_Done !== 1'b1)       begin errors++; $display("[TB] FAIL same_cycle_job_done: got %b want 1", Job_Done); end
    if (wr.Wr_Req !== 1'b0)      begin errors++; $display("[TB] FAIL same_cycle_wr_req: got %b want 0", wr.Wr_Req); end
    if (Round_Cnt !== 16'd1)     begin errors++; $display("[TB] FAIL same_cycle_rounds: got %0d want 1", Round_Cnt); end
    if (wr.Wr_Addr !== 32'h0502) begin errors++; $display("[TB] FAIL same_cycle_addr: got %h want 502", wr.Wr_Addr); end
    end_job();
  endtask

  task automatic test_arm_trigger_ignored();
    bit ok, st; logic [31:0] a; logic [15:0] l;
    start_job(16'd1, 16'd2, 32'h4000, 32'd0);
    wait_arm(ok);
    DDR_WR_Start = 1'b1; ADC_Conv_Done = 1'b1;
    @(negedge Clk); DDR_WR_Start = 1'b0; ADC_Conv_Done = 1'b0;
    repeat (6) @(negedge Clk);
    checks += 2;
    if (wr.Wr_Req !== 1'b0) begin errors++; $display("[TB] FAIL armtrig_no_req: got %b want 0", wr.Wr_Req); end
    if (Busy !== 1'b1)      begin errors++; $display("[TB] FAIL armtrig_waiting: busy got %b want 1", Busy); end
    do_capture(2); wait_req(ok);
    serve_burst(1, a, l, st);
    checks += 2;
    if (a !== 32'h4000)    begin errors++; $display("[TB] FAIL armtrig_addr: got %h want 4000", a); end
    if (Job_Done !== 1'b1) begin errors++; $display("[TB] FAIL armtrig_job_done: got %b want 1", Job_Done); end
    end_job();
  endtask

  task automatic test_abort_wait_trig();
    bit ok;
    int jd0 = job_done_cnt;
    int rq0 = wr_req_cycles;
    start_job(16'd1, 16'd2, 32'h5000, 32'd0);
    wait_arm(ok);
    @(negedge Clk); Cfg_Enable = 1'b0;
    @(negedge Clk);
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_trig_idle: busy got %b want 0", Busy); end
    repeat (5) @(negedge Clk);
    checks += 2;
    if (wr_req_cycles != rq0) begin errors++; $display("[TB] FAIL abort_trig_no_req: got %0d req cycles want 0", wr_req_cycles - rq0); end
    if (job_done_cnt != jd0)  begin errors++; $display("[TB] FAIL abort_trig_no_done: got %0d pulses want 0", job_done_cnt - jd0); end
  endtask

  task automatic test_abort_wait_done();
    bit ok;
    int jd0 = job_done_cnt;
    start_job(16'd2, 16'd2, 32'h6000, 32'd0);
    wait_arm(ok); do_capture(2); wait_req(ok);
    wr.Wr_Ack = 1'b1;
    @(negedge Clk); wr.Wr_Ack = 1'b0; Cfg_Enable = 1'b0;
    repeat (4) @(negedge Clk);
    checks++;
    if (Busy !== 1'b1) begin errors++; $display("[TB] FAIL abort_done_holds: busy got %b want 1", Busy); end
    wr.Wr_Done = 1'b1;
    @(negedge Clk); wr.Wr_Done = 1'b0;
    checks += 2;
    if (Busy !== 1'b0)            begin errors++; $display("[TB] FAIL abort_done_idle: busy got %b want 0", Busy); end
    if (Start_Round_Acq !== 1'b0) begin errors++; $display("[TB] FAIL abort_done_no_arm: got %b want 0", Start_Round_Acq); end
    repeat (3) @(negedge Clk);
    checks++;
    if (job_done_cnt != jd0) begin errors++; $display("[TB] FAIL abort_done_no_done: got %0d pulses want 0", job_done_cnt - jd0); end
  endtask

`ifdef ACQ_TIMEOUT_EN
  task automatic test_timeout();
    bit ok; int idx = -1;
    start_job(16'd1, 16'd2, 32'h7000, 32'd100);
    wait_arm(ok);
    @(negedge Clk);
    for (int i = 1; i <= 150; i++) begin
      @(negedge Clk);
      if (Job_Done === 1'b1) begin idx = i; break; end
    end
    checks += 2;
    if (idx != 100)           begin errors++; $display("[TB] FAIL timeout_cycles: got %0d want 100", idx); end
    if (Timeout_Err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_err_set: got %b want 1", Timeout_Err); end
    end_job();
    checks++;
    if (Timeout_Err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_err_sticky: got %b want 1", Timeout_Err); end
    start_job(16'd1, 16'd2, 32'h7000, 32'd0);
    checks++;
    if (Timeout_Err !== 1'b0) begin errors++; $display("[TB] FAIL timeout_err_cleared: got %b want 0", Timeout_Err); end
    end_job();
  endtask
`else
  task automatic test_timeout();
    bit ok;
    int jd0 = job_done_cnt;
    start_job(16'd1, 16'd2, 32'h7000, 32'd100);
    wait_arm(ok);
    repeat (150) @(negedge Clk);
    checks += 3;
    if (Busy !== 1'b1)        begin errors++; $display("[TB] FAIL no_timeout_waits: busy got %b want 1", Busy); end
    if (Timeout_Err !== 1'b0) begin errors++; $display("[TB] FAIL no_timeout_err: got %b want 0", Timeout_Err); end
    if (job_done_cnt != jd0)  begin errors++; $display("[TB] FAIL no_timeout_done: got %0d pulses want 0", job_done_cnt - jd0); end
    end_job();
  endtask
`endif

  task automatic test_reset_mid_req();
    bit ok;
    start_job(16'd2, 16'd2, 32'h3000, 32'd0);
    wait_arm(ok); do_capture(2); wait_req(ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL rstreq_req: got no Wr_Req want Wr_Req"); end
    #2 Rst_n = 1'b0;
    #1;
    checks += 5;
    if (wr.Wr_Req !== 1'b0)   begin errors++; $display("[TB] FAIL rstreq_wr_req: got %b want 0", wr.Wr_Req); end
    if (Busy !== 1'b0)        begin errors++; $display("[TB] FAIL rstreq_busy: got %b want 0", Busy); end
    if (Round_Cnt !== 16'd0)  begin errors++; $display("[TB] FAIL rstreq_round_cnt: got %0d want 0", Round_Cnt); end
    if (wr.Wr_Addr !== 32'd0) begin errors++; $display("[TB] FAIL rstreq_addr: got %h want 0", wr.Wr_Addr); end
    if (wr.Wr_Len !== 16'd0)  begin errors++; $display("[TB] FAIL rstreq_len: got %0d want 0", wr.Wr_Len); end
    Cfg_Enable = 1'b0;
    @(negedge Clk); Rst_n = 1'b1;
    @(negedge Clk);
  endtask

  initial begin
    wr.Wr_Ack = 1'b0;
    wr.Wr_Done = 1'b0;
    $display("[TB] starting acq_round_sched bench");
    test_reset();
    test_basic();
    test_ack_delay();
    test_wrap();
    test_zero_cfg_same_cycle();
    test_arm_trigger_ignored();
    test_abort_wait_trig();
    test_abort_wait_done();
    test_timeout();
    test_reset_mid_req();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/acq_round_sched.md
ACQ_ROUND_SCHED -- requirements
Module: acq_round_sched

Interface
REQ-001 Parameters SHALL be (name, default, meaning): ADDR_W, 32, DDR byte-address width.
REQ-002 Parameters SHALL be (name, default, meaning): CNT_W, 16, width of the round and sample counters.
REQ-003 Clk  in  1  system clock; all logic SHALL be rising-edge.
REQ-004 Rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Cfg_Enable  in  1  level; rising edge starts a job, low aborts it.
REQ-006 Cfg_Round_Num  in  CNT_W  rounds per job; 0 SHALL be treated as 1.
REQ-007 Cfg_Samples  in  CNT_W  16-bit samples per round; 0 SHALL be treated as 1.
REQ-008 Cfg_Base_Addr  in  ADDR_W  DDR start address of the job.
REQ-009 Cfg_Timeout  in  32  trigger-wait limit in Clk cycles.
REQ-010 ADC_Conv_Done  in  1  one-cycle sample strobe.
REQ-011 DDR_WR_Start  in  1  one-cycle trigger pulse from the trigger detector.
REQ-012 Start_Round_Acq  out  1  one-cycle arm pulse to the trigger detector.
REQ-013 Wr_Req, Wr_Addr[ADDR_W], Wr_Len[CNT_W]  out  burst request to the DDR writer.
REQ-014 Wr_Ack  in  1  request accepted; Wr_Done  in  1  burst complete.
REQ-015 Round_Cnt[CNT_W], Busy, Job_Done (pulse), Timeout_Err (sticky)  out  status.

Function
REQ-016 States SHALL be IDLE, ARM, WAIT_TRIG, CAPTURE, REQ, WAIT_DONE, FINISH.
REQ-017 IDLE->ARM on Cfg_Enable rising edge; Cfg_* SHALL be latched on that cycle, Round_Cnt cleared, Timeout_Err cleared, Wr_Addr<=Cfg_Base_Addr.
REQ-018 ARM SHALL assert Start_Round_Acq for exactly one cycle, then go to WAIT_TRIG.
REQ-019 WAIT_TRIG->CAPTURE on DDR_WR_Start; a trigger arriving in ARM SHALL be ignored.
REQ-020 CAPTURE SHALL count ADC_Conv_Done strobes; the strobe coinciding with the trigger SHALL count as sample 1; ->REQ when the count reaches the latched sample number.
REQ-021 REQ SHALL hold Wr_Req=1 with stable Wr_Addr and Wr_Len=latched samples until the cycle Wr_Ack=1, then ->WAIT_DONE.
REQ-022 WAIT_DONE on Wr_Done: Round_Cnt+1 and Wr_Addr += 2*samples (modulo 2^ADDR_W, wrap allowed); ->FINISH when the count reaches rounds, otherwise ->ARM.
REQ-023 Wr_Ack and Wr_Done in the same cycle SHALL both be honoured (REQ->WAIT_DONE bookkeeping applied, next state as in REQ-022).
REQ-024 FINISH SHALL pulse Job_Done for one cycle and return to IDLE; a new job SHALL require a fresh Cfg_Enable rising edge.
REQ-025 Cfg_Enable low in ARM/WAIT_TRIG/CAPTURE SHALL force IDLE next cycle with no Job_Done; in REQ/WAIT_DONE the in-flight burst SHALL complete (Wr_Done) before IDLE.
REQ-026 Busy SHALL be 1 in every state except IDLE.

Reset
REQ-027 Rst_n low SHALL force IDLE; Start_Round_Acq, Wr_Req, Job_Done, Timeout_Err, Busy=0; Round_Cnt, Wr_Addr, Wr_Len=0.
REQ-028 Reset mid-burst SHALL drop Wr_Req immediately; no recovery of the burst is performed.

Configuration
REQ-029 Macro ACQ_TIMEOUT_EN defined: a 32-bit counter runs in WAIT_TRIG; reaching Cfg_Timeout (non-zero) SHALL set Timeout_Err and go to FINISH; Cfg_Timeout=0 disables the check.
REQ-030 Macro ACQ_TIMEOUT_EN absent: no counter logic, Timeout_Err tied 0, WAIT_TRIG waits indefinitely.

Structure
REQ-031 Package acq_sched_pkg SHALL hold the state encoding (one-hot, 7 bits) and the constant BYTES_PER_SAMPLE=2.
REQ-032 The timeout counter SHALL be a sub-module acq_timeout_cnt (clear, enable, limit, expired), instantiated only under ACQ_TIMEOUT_EN.

Verification
REQ-033 Rounds=2, Samples=4, Base=0x1000, immediate triggers, Wr_Ack 1 cycle after Wr_Req -> bursts at 0x1000 and 0x1008, Len=4, one Job_Done, Round_Cnt=2.
REQ-034 Wr_Ack delayed 5 cycles -> Wr_Req, Wr_Addr, Wr_Len held stable for all 5 cycles.
REQ-035 Base=0xFFFFFFFC, Samples=4, Rounds=2 -> second burst address 0x00000004.
REQ-036 Cfg_Enable dropped in WAIT_TRIG -> IDLE next cycle, no Wr_Req, no Job_Done; dropped in WAIT_DONE -> IDLE only after Wr_Done.
REQ-037 ACQ_TIMEOUT_EN, Cfg_Timeout=100, no trigger -> Timeout_Err=1 and Job_Done pulse 100 cycles after WAIT_TRIG entry.
REQ-038 Rst_n asserted during REQ -> Wr_Req=0 asynchronously, Busy=0, all counters 0.
